// File: rtl/bus_arb_pkg.sv
// Shared encodings for the master-port arbiter: FSM state values and the
// read/write mode constants understood by the bus master device.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: searches req starting one past
// last_winner and returns the first set bit as one-hot plus its index.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_winner,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   idx
);

  always_comb begin
    logic found;
    int   c;
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    c      = 0;
    for (int off = 1; off <= NREQ; off++) begin
      c = int'(last_winner) + off;
      if (c >= NREQ) c = c - NREQ;
      if (!found && req[IW'(c)]) begin
        found             = 1'b1;
        winner[IW'(c)]    = 1'b1;
        idx               = IW'(c);
      end
    end
  end

endmodule

// File: rtl/master_port_arbiter.sv
// Round-robin sequencer sharing one bus master port among NREQ clients.
// Optional WAIT-state timeout with err flag is built when ARB_TIMEOUT_EN is defined.
module master_port_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int VALID_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            req_rw,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       err,
  output logic                       busy,
  output logic [ADDR_WIDTH-1:0]      d1_addr,
  output logic [DATA_WIDTH-1:0]      d1_wdata,
  output logic                       d1_valid,
  output logic                       m1_rw_mode,
  input  logic [DATA_WIDTH-1:0]      d1_rdata,
  input  logic                       m1_ready
);

  localparam int IW = $clog2(NREQ);
  localparam int VW = $clog2(VALID_CYCLES + 1);

  state_t          state;
  logic [IW-1:0]   last_winner;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] pick;
  logic [IW-1:0]   pick_idx;
  logic [VW-1:0]   vcnt;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tcnt;
`else
  assign err = 1'b0;
`endif

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
    .req         (req),
    .last_winner (last_winner),
    .winner      (pick),
    .idx         (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      gnt         <= '0;
      done        <= '0;
      rdata       <= '0;
      busy        <= 1'b0;
      d1_valid    <= 1'b0;
      d1_addr     <= '0;
      d1_wdata    <= '0;
      m1_rw_mode  <= MODE_READ;
      last_winner <= IW'(NREQ - 1);
      win_idx     <= '0;
      vcnt        <= '0;
`ifdef ARB_TIMEOUT_EN
      err         <= 1'b0;
      tcnt        <= '0;
`endif
    end else begin
      done <= '0;
      case (state)
        // Gate on m1_ready so a master still finishing an aborted transfer is never re-issued to.
        IDLE: begin
          if ((|req) && m1_ready) begin
            state      <= ISSUE;
            gnt        <= pick;
            win_idx    <= pick_idx;
            busy       <= 1'b1;
            d1_valid   <= 1'b1;
            vcnt       <= VW'(1);
            d1_addr    <= req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            d1_wdata   <= req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            m1_rw_mode <= req_rw[pick_idx];
`ifdef ARB_TIMEOUT_EN
            err        <= 1'b0;
`endif
          end
        end
        ISSUE: begin
          if (vcnt == VW'(VALID_CYCLES)) begin
            d1_valid <= 1'b0;
            state    <= WAIT;
`ifdef ARB_TIMEOUT_EN
            tcnt     <= '0;
`endif
          end else begin
            vcnt <= vcnt + 1'b1;
          end
        end
        // The master drops m1_ready while valid is high, so the first ready seen here is completion.
        WAIT: begin
          if (m1_ready) begin
            if (m1_rw_mode == MODE_READ) rdata <= d1_rdata;
            done  <= gnt;
            state <= RESP;
          end
`ifdef ARB_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            err   <= 1'b1;
            done  <= gnt;
            state <= RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        RESP: begin
          gnt         <= '0;
          busy        <= 1'b0;
          last_winner <= win_idx;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/master_port_arbiter.md
# master_port_arbiter

Round-robin arbiter and sequencer that shares the single bus master device port (d1_addr/d1_wdata/d1_valid/m1_rw_mode, returning d1_rdata/m1_ready) among NREQ local requesters. It sits between on-chip clients (demo controllers, BRAM loaders, UART command handlers) and the master interface of the bus top. It owns the issue pulse and the completion wait, so clients only do a req/done handshake.

## Interface
- NREQ, 4: number of requesters, ≥2
- ADDR_WIDTH, 16: bus address width
- DATA_WIDTH, 8: bus data width
- VALID_CYCLES, 2: cycles d1_valid is held high per transaction, ≥1
- TIMEOUT_CYCLES, 1023: WAIT-state limit, only used with ARB_TIMEOUT_EN
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- req  in  NREQ  per-client request level
- req_rw  in  NREQ  per-client mode, 1 write / 0 read
- req_addr  in  NREQ*ADDR_WIDTH  packed addresses, client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NREQ*DATA_WIDTH  packed write data, same packing
- gnt  out  NREQ  one-hot grant, held for the whole transaction
- done  out  NREQ  one-hot, one-cycle completion pulse
- rdata  out  DATA_WIDTH  last read data
- err  out  1  timeout flag, valid with done
- busy  out  1  high when state ≠ IDLE
- d1_addr  out  ADDR_WIDTH  to master port
- d1_wdata  out  DATA_WIDTH  to master port
- d1_valid  out  1  to master port
- m1_rw_mode  out  1  to master port
- d1_rdata  in  DATA_WIDTH  from master port
- m1_ready  in  1  from master port, high when master idle

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req bit set and m1_ready=1, pick winner via round-robin starting at last_winner+1 (mod NREQ); latch its addr/wdata/rw into d1_addr/d1_wdata/m1_rw_mode, set gnt[winner], d1_valid=1, go ISSUE. If m1_ready=0, no grant.
- ISSUE: d1_valid stays high for VALID_CYCLES total, then drops; go WAIT.
- WAIT: on m1_ready=1, capture d1_rdata into rdata if m1_rw_mode=0 (writes leave rdata unchanged); go RESP.
- RESP: done[winner]=1 for one cycle, gnt still held; last_winner←winner; go IDLE, gnt cleared.
- Client must hold req/rw/addr/wdata stable until grant; values after grant are ignored. req dropped mid-transaction does not abort it.
- Master accepts the transaction and drops m1_ready within VALID_CYCLES of d1_valid rising; the arbiter relies on this and does not search for a falling edge.
- Reset values: state IDLE, gnt 0, done 0, rdata 0, err 0, busy 0, d1_valid 0, d1_addr 0, d1_wdata 0, m1_rw_mode 0, last_winner NREQ-1 (client 0 has first priority).
- Reset mid-transaction: all outputs return to reset values next edge; the in-flight transaction gets no done. The IDLE m1_ready gate keeps the arbiter from issuing until the master finishes.

## Timing
- Cycle 0: IDLE with req and m1_ready sampled high. Cycles 1..VALID_CYCLES: gnt and d1_valid high.
- WAIT begins at cycle VALID_CYCLES+1; m1_ready high sampled in WAIT cycle k puts done at k+1.
- Minimum period is VALID_CYCLES+3 cycles per transaction, with one mandatory IDLE cycle between grants.
- A req arriving during a transaction is served at the next IDLE.

## Configuration
- ARB_TIMEOUT_EN defined: WAIT counts cycles. When the count reaches TIMEOUT_CYCLES without m1_ready, go RESP with err=1 alongside done, and leave rdata unchanged. err clears at the next grant.
- Not defined: WAIT is unbounded, err is tied 0, and no counter is instantiated.

## Structure
- Package bus_arb_pkg: state encoding localparams (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, RESP=2'b11) and the MODE_READ/MODE_WRITE constants shared with the master device.
- Sub-module rr_picker: combinational round-robin priority encoder. Inputs req and last_winner; outputs a one-hot winner and its index.

## Test plan
- Single write, client 2 (addr 0x4001, data 0xA5), with m1_ready dropping 1 cycle after valid and returning 6 cycles later → d1_valid high exactly 2 cycles, m1_rw_mode=1, done[2] one cycle after m1_ready rises, rdata unchanged.
- Single read, client 0, with d1_rdata=0x3C at completion → rdata=0x3C, done[0] pulse, err=0.
- All four req held continuously → grants in order 0,1,2,3,0 and never two gnt bits high at once.
- m1_ready held low at grant time → no gnt and no d1_valid until m1_ready=1.
- rstn asserted during WAIT → next cycle all outputs at reset values, no done; after release, grants resume only once m1_ready=1.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, m1_ready stuck low → done and err high together after 8 WAIT cycles; next grant clears err.
